// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS main control FSM with memory wait states and watchdog
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWr,
  output logic       PCWrCond,
  output logic [1:0] PCSrc,
  output logic       IRWr,
  output logic       MemRd,
  output logic       MemWr,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       ExtOp,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       InstrDone,
  output logic       Fault,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXE_R   = 4'd2,
    EXE_I   = 4'd3,
    MEM_ADR = 4'd4,
    MEM_RD  = 4'd5,
    MEM_WR  = 4'd6,
    WB_LW   = 4'd7,
    WB_R    = 4'd8,
    WB_I    = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11,
    HALT    = 4'd12
  } state_t;

  // Moore control word; registered from the next state so it lines up with the state register.
  typedef struct packed {
    logic       pcwr;
    logic       pcwrcond;
    logic [1:0] pcsrc;
    logic       memrd;
    logic       memwr;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       extop;
    logic       regwr;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       done;
  } ctl_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_n;
  ctl_t       ctl;
  logic [7:0] wd;
  logic       fault;
  logic       waiting;
  logic       timeout;
  logic       unknown_op;
  logic       unused_zero;

  // The branch decision is taken by the datapath through PCWrCond, so Zero is not needed here.
  assign unused_zero = Zero;

  // Instruction class to first execution state; FETCH means the encoding runs as a nop.
  function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] funct);
    state_t t;
    t = FETCH;
    case (op)
      6'b000000:
        if (funct == 6'b100001 || funct == 6'b100011) t = EXE_R;
        else if (funct == 6'b001000) t = JUMP;
      6'b001101, 6'b001111: t = EXE_I;
      6'b100011, 6'b101011: t = MEM_ADR;
      6'b000100:            t = BRANCH;
      6'b000010, 6'b000011: t = JUMP;
      default:              t = FETCH;
    endcase
    return t;
  endfunction

  // Datapath control word for a state; op only matters in JUMP and WB_I.
  function automatic ctl_t ctl_for(input state_t st, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (st)
      FETCH: begin
        c.memrd   = 1'b1;
        c.alusrcb = 2'b01;
      end
      DECODE: begin
        c.alusrcb = 2'b11;
        c.extop   = 1'b1;
      end
      EXE_R: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b11;
      end
      EXE_I: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = 2'b10;
      end
      MEM_ADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.extop   = 1'b1;
      end
      MEM_RD: begin
        c.memrd = 1'b1;
        c.iord  = 1'b1;
      end
      MEM_WR: begin
        c.memwr = 1'b1;
        c.iord  = 1'b1;
      end
      WB_LW: begin
        c.regwr    = 1'b1;
        c.memtoreg = 2'b01;
        c.done     = 1'b1;
      end
      WB_R: begin
        c.regwr  = 1'b1;
        c.regdst = 2'b01;
        c.done   = 1'b1;
      end
      WB_I: begin
        c.regwr    = 1'b1;
        c.memtoreg = (op == 6'b001111) ? 2'b11 : 2'b00;
        c.done     = 1'b1;
      end
      BRANCH: begin
        c.alusrca  = 1'b1;
        c.aluop    = 2'b01;
        c.pcwrcond = 1'b1;
        c.pcsrc    = 2'b01;
        c.done     = 1'b1;
      end
      JUMP: begin
        c.pcwr  = 1'b1;
        c.pcsrc = (op == 6'b000000) ? 2'b11 : 2'b10;
        c.done  = 1'b1;
        if (op == 6'b000011) begin
          c.regwr    = 1'b1;
          c.regdst   = 2'b10;
          c.memtoreg = 2'b10;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection: reset first, then watchdog expiry, then normal sequencing.
  always_comb begin
    waiting    = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    timeout    = waiting && !MemReady && (wd == WD_LAST);
    unknown_op = (decode_target(Op, Funct) == FETCH);
    state_n    = state;
    if (Reset) begin
      state_n = FETCH;
    end else if (timeout) begin
      state_n = HALT;
    end else begin
      case (state)
        FETCH:   if (MemReady) state_n = DECODE;
        DECODE:  state_n = decode_target(Op, Funct);
        EXE_R:   state_n = WB_R;
        EXE_I:   state_n = WB_I;
        MEM_ADR: state_n = Op[3] ? MEM_WR : MEM_RD;
        MEM_RD:  if (MemReady) state_n = WB_LW;
        MEM_WR:  if (MemReady) state_n = FETCH;
        WB_LW, WB_R, WB_I, BRANCH, JUMP: state_n = FETCH;
        HALT:    state_n = HALT;
        default: state_n = FETCH;
      endcase
    end
  end

  // State, registered control word, watchdog count and sticky fault flag.
  always_ff @(posedge Clk) begin
    state <= state_n;
    ctl   <= ctl_for(state_n, Op);
    if (Reset) begin
      wd    <= 8'd0;
      fault <= 1'b0;
    end else begin
      wd <= (waiting && !MemReady && (state_n == state)) ? wd + 8'd1 : 8'd0;
      if (state_n == HALT) fault <= 1'b1;
    end
  end

  // Strobes are suppressed while Reset is high; fetch and store completion follow MemReady directly.
  assign PCWr      = ~Reset & (ctl.pcwr | ((state == FETCH) & MemReady));
  assign PCWrCond  = ~Reset & ctl.pcwrcond;
  assign PCSrc     = ctl.pcsrc;
  assign IRWr      = ~Reset & (state == FETCH) & MemReady;
  assign MemRd     = ~Reset & ctl.memrd;
  assign MemWr     = ~Reset & ctl.memwr;
  assign IorD      = ctl.iord;
  assign ALUSrcA   = ctl.alusrca;
  assign ALUSrcB   = ctl.alusrcb;
  assign ALUOp     = ctl.aluop;
  assign ExtOp     = ctl.extop;
  assign RegWr     = ~Reset & ctl.regwr;
  assign RegDst    = ctl.regdst;
  assign MemToReg  = ctl.memtoreg;
  assign InstrDone = ~Reset & (ctl.done | ((state == DECODE) & unknown_op) | ((state == MEM_WR) & MemReady));
  assign Fault     = fault;
  assign State     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWr, PCWrCond, IRWr, MemRd, MemWr, IorD, ALUSrcA, ExtOp, RegWr, InstrDone, Fault;
  logic [1:0] PCSrc, ALUSrcB, ALUOp, RegDst, MemToReg;
  logic [3:0] State;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] st;
    logic       pcwr;
    logic       pcwrcond;
    logic [1:0] pcsrc;
    logic       memrd;
    logic       memwr;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       extop;
    logic       regwr;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       done;
    logic       fault;
  } obs_t;

  obs_t obs[$];
  int   exp_st[$];
  int   n_regwr, n_memwr, n_memrd, n_done, n_irwr, n_pcwr;

  // instruction classes: addu subu ori lui lw sw beq j jal jr illegal
  logic [5:0] cls_op [0:10] = '{6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h00, 6'h3f};
  logic [5:0] cls_fn [0:10] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00};

  multicycle_ctrl #(.TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .PCSrc(PCSrc), .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtOp(ExtOp), .RegWr(RegWr),
    .RegDst(RegDst), .MemToReg(MemToReg), .InstrDone(InstrDone), .Fault(Fault), .State(State)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Expected state trace from the instruction class and the number of wait cycles.
  function automatic void build_expected(input int cls, input int fw, input int mw);
    exp_st.delete();
    repeat (fw + 1) exp_st.push_back(0);
    exp_st.push_back(1);
    case (cls)
      0, 1: begin exp_st.push_back(2); exp_st.push_back(8); end
      2, 3: begin exp_st.push_back(3); exp_st.push_back(9); end
      4: begin exp_st.push_back(4); repeat (mw + 1) exp_st.push_back(5); exp_st.push_back(7); end
      5: begin exp_st.push_back(4); repeat (mw + 1) exp_st.push_back(6); end
      6: exp_st.push_back(10);
      7, 8, 9: exp_st.push_back(11);
      default: ;
    endcase
  endfunction

  function automatic string obs_str();
    string s = "";
    foreach (obs[i]) s = {s, $sformatf("%0d ", obs[i].st)};
    return s;
  endfunction

  function automatic string exp_str();
    string s = "";
    foreach (exp_st[i]) s = {s, $sformatf("%0d ", exp_st[i])};
    return s;
  endfunction

  task automatic apply_reset();
    Reset = 1'b1;
    MemReady = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  // Drives one instruction from FETCH until InstrDone or Fault, recording every cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input logic z);
    int fc = 0;
    int mc = 0;
    bit fin = 0;
    obs_t o;
    obs.delete();
    n_regwr = 0; n_memwr = 0; n_memrd = 0; n_done = 0; n_irwr = 0; n_pcwr = 0;
    Op = op; Funct = fn; Zero = z;
    while (!fin && obs.size() < 40) begin
      if (State == 4'd0) begin
        MemReady = (fc >= fw); fc++;
      end else if (State == 4'd5 || State == 4'd6) begin
        MemReady = (mc >= mw); mc++;
      end else begin
        MemReady = 1'($urandom_range(0, 1));
      end
      @(negedge Clk);
      o.st = State; o.pcwr = PCWr; o.pcwrcond = PCWrCond; o.pcsrc = PCSrc; o.memrd = MemRd;
      o.memwr = MemWr; o.alusrcb = ALUSrcB; o.aluop = ALUOp; o.extop = ExtOp; o.regwr = RegWr;
      o.regdst = RegDst; o.memtoreg = MemToReg; o.done = InstrDone; o.fault = Fault;
      obs.push_back(o);
      n_regwr += int'(RegWr); n_memwr += int'(MemWr); n_memrd += int'(MemRd);
      n_done += int'(InstrDone); n_irwr += int'(IRWr); n_pcwr += int'(PCWr);
      if (InstrDone === 1'b1 || Fault === 1'b1) fin = 1;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; MemReady = 1'b1; Op = 6'h00; Funct = 6'h00;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", State); end
    checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", Fault); end
    checks++; if (MemRd !== 1'b0 || IRWr !== 1'b0 || PCWr !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: MemRd=%b IRWr=%b PCWr=%b want 000", MemRd, IRWr, PCWr);
    end
    Reset = 1'b0;
    #1;
    checks++; if (MemRd !== 1'b1 || IRWr !== 1'b1 || PCWr !== 1'b1) begin
      errors++; $display("FAIL fetch_strobes: MemRd=%b IRWr=%b PCWr=%b want 111", MemRd, IRWr, PCWr);
    end
    checks++; if (IorD !== 1'b0 || ALUSrcA !== 1'b0 || ALUSrcB !== 2'b01 || ALUOp !== 2'b00 || PCSrc !== 2'b00) begin
      errors++; $display("FAIL fetch_mux: IorD=%b SrcA=%b SrcB=%b ALUOp=%b PCSrc=%b want 0 0 01 00 00",
                         IorD, ALUSrcA, ALUSrcB, ALUOp, PCSrc);
    end
    MemReady = 1'b0;
    #1;
    checks++; if (IRWr !== 1'b0 || PCWr !== 1'b0) begin
      errors++; $display("FAIL fetch_wait: IRWr=%b PCWr=%b want 00", IRWr, PCWr);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_addu();
    bit ok = 1;
    apply_reset();
    run_instr(6'h00, 6'h21, 0, 0, 1'b0);
    build_expected(0, 0, 0);
    checks++; if (obs_str() != exp_str()) begin errors++; $display("FAIL addu_states: got %s want %s", obs_str(), exp_str()); end
    foreach (obs[i]) if (obs[i].regwr !== (i == 3)) ok = 0;
    checks++; if (!ok || obs.size() != 4) begin errors++; $display("FAIL addu_regwr: got count %0d want 1 in cycle 4", n_regwr); end
    checks++; if (obs.size() == 4 && obs[3].regdst !== 2'b01) begin errors++; $display("FAIL addu_regdst: got %b want 01", obs[3].regdst); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL addu_done: got %0d pulses want 1", n_done); end
  endtask

  task automatic test_lw_wait();
    int rd5 = 0;
    apply_reset();
    run_instr(6'h23, 6'h00, 0, 2, 1'b0);
    build_expected(4, 0, 2);
    checks++; if (obs_str() != exp_str()) begin errors++; $display("FAIL lw_states: got %s want %s", obs_str(), exp_str()); end
    foreach (obs[i]) if (obs[i].st == 4'd5 && obs[i].memrd === 1'b1) rd5++;
    checks++; if (rd5 != 3) begin errors++; $display("FAIL lw_memrd: got %0d cycles want 3", rd5); end
    checks++; if (obs.size() != 7 || obs[obs.size()-1].memtoreg !== 2'b01 || obs[obs.size()-1].regwr !== 1'b1) begin
      errors++; $display("FAIL lw_wb: got len %0d want 7 with RegWr=1 MemToReg=01", obs.size());
    end
  endtask

  task automatic test_beq();
    for (int z = 0; z < 2; z++) begin
      run_instr(6'h04, 6'h00, 0, 0, 1'(z));
      checks++; if (obs.size() != 3 || obs[2].st !== 4'd10) begin
        errors++; $display("FAIL beq_states z=%0d: got %s want 0 1 10", z, obs_str());
      end else if (obs[2].pcwrcond !== 1'b1 || obs[2].pcsrc !== 2'b01 || obs[2].aluop !== 2'b01 || obs[2].pcwr !== 1'b0) begin
        errors++; $display("FAIL beq_ctl z=%0d: PCWrCond=%b PCSrc=%b ALUOp=%b PCWr=%b want 1 01 01 0",
                           z, obs[2].pcwrcond, obs[2].pcsrc, obs[2].aluop, obs[2].pcwr);
      end
    end
  endtask

  task automatic test_jumps();
    run_instr(6'h03, 6'h00, 0, 0, 1'b0);
    checks++; if (obs.size() != 3 || obs[2].pcwr !== 1'b1 || obs[2].pcsrc !== 2'b10 || obs[2].regwr !== 1'b1 ||
                  obs[2].regdst !== 2'b10 || obs[2].memtoreg !== 2'b10) begin
      errors++; $display("FAIL jal: got states %s last PCWr=%b PCSrc=%b RegWr=%b RegDst=%b MemToReg=%b want 1 10 1 10 10",
                         obs_str(), obs[obs.size()-1].pcwr, obs[obs.size()-1].pcsrc, obs[obs.size()-1].regwr,
                         obs[obs.size()-1].regdst, obs[obs.size()-1].memtoreg);
    end
    run_instr(6'h00, 6'h08, 1, 0, 1'b0);
    checks++; if (obs.size() != 4 || obs[3].pcwr !== 1'b1 || obs[3].pcsrc !== 2'b11 || obs[3].regwr !== 1'b0) begin
      errors++; $display("FAIL jr: got states %s last PCWr=%b PCSrc=%b RegWr=%b want 1 11 0",
                         obs_str(), obs[obs.size()-1].pcwr, obs[obs.size()-1].pcsrc, obs[obs.size()-1].regwr);
    end
  endtask

  task automatic test_imm();
    run_instr(6'h0d, 6'h15, 0, 0, 1'b0);
    checks++; if (obs.size() != 4 || obs[2].extop !== 1'b0 || obs[2].aluop !== 2'b10 || obs[2].alusrcb !== 2'b10 ||
                  obs[3].memtoreg !== 2'b00 || obs[3].regdst !== 2'b00 || obs[3].regwr !== 1'b1) begin
      errors++; $display("FAIL ori: got states %s", obs_str());
    end
    run_instr(6'h0f, 6'h2a, 0, 0, 1'b0);
    checks++; if (obs.size() != 4 || obs[3].memtoreg !== 2'b11 || obs[3].regwr !== 1'b1) begin
      errors++; $display("FAIL lui: got states %s last MemToReg=%b want 11", obs_str(), obs[obs.size()-1].memtoreg);
    end
  endtask

  task automatic test_illegal();
    run_instr(6'h3f, 6'h3f, 0, 0, 1'b0);
    checks++; if (obs_str() != "0 1 " || obs[1].done !== 1'b1 || n_regwr != 0 || n_memwr != 0) begin
      errors++; $display("FAIL illegal: got states %s RegWr=%0d MemWr=%0d want 0 1 with InstrDone", obs_str(), n_regwr, n_memwr);
    end
  endtask

  task automatic test_watchdog();
    apply_reset();
    MemReady = 1'b0;
    repeat (15) @(posedge Clk);
    #1;
    checks++; if (State !== 4'd0 || Fault !== 1'b0) begin errors++; $display("FAIL wd_early: State=%0d Fault=%b want 0 0", State, Fault); end
    @(posedge Clk); #1;
    checks++; if (State !== 4'd12 || Fault !== 1'b1 || MemRd !== 1'b0) begin
      errors++; $display("FAIL wd_halt: State=%0d Fault=%b MemRd=%b want 12 1 0", State, Fault, MemRd);
    end
    MemReady = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (State !== 4'd12 || Fault !== 1'b1 || IRWr !== 1'b0 || PCWr !== 1'b0) begin
      errors++; $display("FAIL wd_sticky: State=%0d Fault=%b IRWr=%b PCWr=%b want 12 1 0 0", State, Fault, IRWr, PCWr);
    end
    apply_reset();
    checks++; if (State !== 4'd0 || Fault !== 1'b0) begin errors++; $display("FAIL wd_reset: State=%0d Fault=%b want 0 0", State, Fault); end
    run_instr(6'h23, 6'h00, 0, 100, 1'b0);
    checks++; if (obs.size() != 20 || obs[19].st !== 4'd12 || obs[19].fault !== 1'b1 || n_regwr != 0) begin
      errors++; $display("FAIL wd_memrd: got len %0d states %s want 20 ending in 12", obs.size(), obs_str());
    end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    Op = 6'h2b; Funct = 6'h00; MemReady = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    MemReady = 1'b0;
    @(negedge Clk);
    checks++; if (State !== 4'd6 || MemWr !== 1'b1) begin errors++; $display("FAIL midrst_memwr: State=%0d MemWr=%b want 6 1", State, MemWr); end
    Reset = 1'b1;
    #1;
    checks++; if (MemWr !== 1'b0 || InstrDone !== 1'b0) begin errors++; $display("FAIL midrst_gate: MemWr=%b InstrDone=%b want 0 0", MemWr, InstrDone); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    checks++; if (State !== 4'd0 || MemWr !== 1'b0 || RegWr !== 1'b0) begin
      errors++; $display("FAIL midrst_after: State=%0d MemWr=%b RegWr=%b want 0 0 0", State, MemWr, RegWr);
    end
  endtask

  task automatic test_back_to_back();
    int cls, fw, mw, e_regwr, e_memwr, e_memrd, e_pcwr;
    logic [5:0] op, fn;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      cls = $urandom_range(0, 10);
      fw  = $urandom_range(0, 3);
      mw  = $urandom_range(0, 3);
      op  = cls_op[cls];
      fn  = (op == 6'h00) ? cls_fn[cls] : 6'($urandom);
      if (cls == 10 && $urandom_range(0, 1) == 1) begin op = 6'h00; fn = 6'h00; end
      run_instr(op, fn, fw, mw, 1'($urandom_range(0, 1)));
      build_expected(cls, fw, mw);
      e_regwr = (cls <= 4 || cls == 8) ? 1 : 0;
      e_memwr = (cls == 5) ? mw + 1 : 0;
      e_memrd = fw + 1 + ((cls == 4) ? mw + 1 : 0);
      e_pcwr  = 1 + ((cls >= 7 && cls <= 9) ? 1 : 0);
      checks++; if (obs_str() != exp_str()) begin
        errors++; $display("FAIL rnd_states n=%0d cls=%0d: got %s want %s", n, cls, obs_str(), exp_str());
      end
      checks++; if (n_done != 1 || obs[obs.size()-1].done !== 1'b1) begin
        errors++; $display("FAIL rnd_done n=%0d cls=%0d: got %0d pulses want 1 in last cycle", n, cls, n_done);
      end
      checks++; if (n_regwr != e_regwr || n_memwr != e_memwr || n_memrd != e_memrd) begin
        errors++; $display("FAIL rnd_strobes n=%0d cls=%0d: RegWr=%0d MemWr=%0d MemRd=%0d want %0d %0d %0d",
                           n, cls, n_regwr, n_memwr, n_memrd, e_regwr, e_memwr, e_memrd);
      end
      checks++; if (n_irwr != 1 || n_pcwr != e_pcwr || obs[obs.size()-1].fault !== 1'b0) begin
        errors++; $display("FAIL rnd_pc n=%0d cls=%0d: IRWr=%0d PCWr=%0d want 1 %0d", n, cls, n_irwr, n_pcwr, e_pcwr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jumps();
    test_imm();
    test_illegal();
    test_watchdog();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
